// File: rtl/imem_loader.sv
// Boot loader: parses a framed host byte stream into 32-bit words for the instruction
// memory, and holds the core in reset until a frame loads with a matching checksum.
module imem_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned LEN_CMP_W = 17;
    localparam logic [LEN_CMP_W-1:0] MAX_WORDS = LEN_CMP_W'(1 << ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM
    } state_t;

    state_t              state;
    logic [7:0]          len_lo;
    logic [ADDR_W-1:0]   last_idx;
    logic [ADDR_W-1:0]   word_idx;
    logic [1:0]          byte_cnt;
    logic [23:0]         word_buf;
    logic [7:0]          csum;

    logic                 accept;
    logic [LEN_CMP_W-1:0] n_words;

    assign accept  = rx_valid && rx_ready;
    assign n_words = {1'b0, rx_data, len_lo};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            len_lo     <= '0;
            last_idx   <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            word_buf   <= '0;
            csum       <= '0;
        end else begin
            rx_ready <= 1'b1;
            imem_we  <= 1'b0;
            if (accept) begin
                case (state)
                    S_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            state      <= S_LEN_LO;
                            busy       <= 1'b1;
                            done       <= 1'b0;
                            err        <= 1'b0;
                            core_reset <= 1'b1;
                            word_idx   <= '0;
                            byte_cnt   <= '0;
                            csum       <= '0;
                        end
                    end
                    S_LEN_LO: begin
                        len_lo <= rx_data;
                        state  <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        // Reject empty frames and frames larger than the memory.
                        if (n_words == '0 || n_words > MAX_WORDS) begin
                            err   <= 1'b1;
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            last_idx <= ADDR_W'(n_words - LEN_CMP_W'(1));
                            state    <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        word_buf <= {rx_data, word_buf[23:8]};
                        csum     <= csum ^ rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        // Fourth byte completes a little-endian word.
                        if (byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_idx;
                            imem_wdata <= {rx_data, word_buf};
                            word_idx   <= word_idx + ADDR_W'(1);
                            if (word_idx == last_idx) begin
                                state <= S_CSUM;
                            end
                        end
                    end
                    S_CSUM: begin
                        if (rx_data == csum) begin
                            done       <= 1'b1;
                            core_reset <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-position reference model compared every
// cycle, plus literal expectations for the directed load scenarios.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 8;
    localparam logic [7:0]  SYNC   = 8'hA5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              busy;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(SYNC)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: tracks position within the frame rather than a state machine.
    logic              m_ready, m_we, m_core, m_busy, m_done, m_err;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata, m_word;
    logic [7:0]        m_lo, m_acc, m_b;
    int                m_pos, m_n, m_k;
    bit                m_take;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ready = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
            m_core = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
            m_pos = 0; m_n = 0; m_acc = 8'h00; m_lo = 8'h00; m_word = '0;
        end else begin
            m_take  = rx_valid && m_ready;
            m_ready = 1'b1;
            m_we    = 1'b0;
            m_b     = rx_data;
            if (m_take) begin
                if (m_pos == 0) begin
                    if (m_b == SYNC) begin
                        m_pos = 1; m_done = 1'b0; m_err = 1'b0; m_core = 1'b1; m_acc = 8'h00;
                    end
                end else if (m_pos == 1) begin
                    m_lo = m_b; m_pos = 2;
                end else if (m_pos == 2) begin
                    m_n = int'({m_b, m_lo});
                    if (m_n == 0 || m_n > (1 << ADDR_W)) begin
                        m_err = 1'b1; m_pos = 0;
                    end else begin
                        m_pos = 3;
                    end
                end else if (m_pos < 3 + 4 * m_n) begin
                    m_k = m_pos - 3;
                    m_word[8 * (m_k % 4) +: 8] = m_b;
                    m_acc = m_acc ^ m_b;
                    if (m_k % 4 == 3) begin
                        m_we = 1'b1; m_addr = ADDR_W'(m_k / 4); m_wdata = m_word;
                    end
                    m_pos++;
                end else begin
                    if (m_b == m_acc) begin m_done = 1'b1; m_core = 1'b0; end
                    else m_err = 1'b1;
                    m_pos = 0;
                end
            end
            m_busy = (m_pos != 0);
        end
    end

    always @(negedge clk) begin
        chk("rx_ready",   32'(rx_ready),   32'(m_ready));
        chk("imem_we",    32'(imem_we),    32'(m_we));
        chk("imem_addr",  32'(imem_addr),  32'(m_addr));
        chk("imem_wdata", imem_wdata,      m_wdata);
        chk("core_reset", 32'(core_reset), 32'(m_core));
        chk("busy",       32'(busy),       32'(m_busy));
        chk("done",       32'(done),       32'(m_done));
        chk("err",        32'(err),        32'(m_err));
    end

    logic [ADDR_W-1:0] wl_addr[$];
    logic [31:0]       wl_data[$];
    always @(negedge clk) begin
        if (imem_we) begin
            wl_addr.push_back(imem_addr);
            wl_data.push_back(imem_wdata);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    logic [7:0]  bq[$];
    logic [31:0] fw[$];

    task automatic send_q();
        foreach (bq[i]) send(bq[i]);
    endtask

    task automatic send_frame(input int len, input bit bad, input int gap_pct);
        logic [7:0] cs;
        logic [7:0] b;
        logic [31:0] w;
        logic [15:0] l16;
        l16 = 16'(len);
        cs = 8'h00;
        send(SYNC);
        send(l16[7:0]);
        send(l16[15:8]);
        if (len == 0 || len > (1 << ADDR_W)) return;
        for (int i = 0; i < len; i++) begin
            w = fw[i];
            for (int k = 0; k < 4; k++) begin
                b = w[8 * k +: 8];
                cs = cs ^ b;
                send(b);
                if ($urandom_range(99) < 32'(gap_pct)) idle($urandom_range(3, 1));
            end
        end
        send(bad ? ~cs : cs);
    endtask

    task automatic clear_log();
        wl_addr.delete();
        wl_data.delete();
    endtask

    task automatic check_s1(input string tag);
        chk({tag, "_nwrites"}, 32'(wl_addr.size()), 32'd2);
        if (wl_addr.size() == 2) begin
            chk({tag, "_addr0"}, 32'(wl_addr[0]), 32'd0);
            chk({tag, "_data0"}, wl_data[0], 32'h05000820);
            chk({tag, "_addr1"}, 32'(wl_addr[1]), 32'd1);
            chk({tag, "_data1"}, wl_data[1], 32'h44332211);
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_core_reset"}, 32'(core_reset), 32'd0);
    endtask

    initial begin
        int len;
        bit bad;
        logic [7:0] nb;

        idle(3);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        reset = 1'b0;
        idle(1);
        chk("post_rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Scenario 1: valid two-word load.
        clear_log();
        bq = '{8'hA5, 8'h02, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05,
               8'h11, 8'h22, 8'h33, 8'h44};
        send_q();
        chk("s1_core_reset_before_csum", 32'(core_reset), 32'd1);
        send(8'h69);
        chk("s1_core_reset_after_csum", 32'(core_reset), 32'd0);
        idle(2);
        check_s1("s1");

        // Scenario 2: bad checksum, then a good frame.
        clear_log();
        bq[0] = 8'hA5;
        send_q();
        send(8'h00);
        idle(2);
        chk("s2_nwrites", 32'(wl_addr.size()), 32'd2);
        chk("s2_err", 32'(err), 32'd1);
        chk("s2_done", 32'(done), 32'd0);
        chk("s2_core_reset", 32'(core_reset), 32'd1);
        clear_log();
        send_q();
        send(8'h69);
        idle(2);
        check_s1("s2b");

        // Scenario 3: length bounds.
        clear_log();
        send_frame(0, 1'b0, 0);
        idle(2);
        chk("s3_len0_err", 32'(err), 32'd1);
        chk("s3_len0_nwrites", 32'(wl_addr.size()), 32'd0);
        send_frame(257, 1'b0, 0);
        idle(2);
        chk("s3_len257_err", 32'(err), 32'd1);
        chk("s3_len257_nwrites", 32'(wl_addr.size()), 32'd0);
        fw.delete();
        for (int i = 0; i < 256; i++) fw.push_back($urandom);
        send_frame(256, 1'b0, 0);
        idle(2);
        chk("s3_len256_nwrites", 32'(wl_addr.size()), 32'd256);
        if (wl_addr.size() == 256) chk("s3_last_addr", 32'(wl_addr[255]), 32'hFF);
        chk("s3_len256_done", 32'(done), 32'd1);

        // Scenario 4: idle noise and a 3-cycle gap mid-word.
        clear_log();
        send(8'h00); send(8'hFF); send(8'h5A);
        chk("s4_noise_busy", 32'(busy), 32'd0);
        bq = '{8'hA5, 8'h02, 8'h00, 8'h20, 8'h08};
        send_q();
        idle(3);
        bq = '{8'h00, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h69};
        send_q();
        idle(2);
        check_s1("s4");

        // Scenario 5: sync value as plain data.
        clear_log();
        bq = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5};
        send_q();
        idle(2);
        chk("s5_nwrites", 32'(wl_addr.size()), 32'd1);
        if (wl_addr.size() == 1) chk("s5_data", wl_data[0], 32'h000000A5);
        chk("s5_done", 32'(done), 32'd1);

        // Scenario 6: asynchronous reset mid-word.
        bq = '{8'hA5, 8'h02, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05, 8'h11, 8'h22};
        send_q();
        #2 reset = 1'b1;
        #1;
        chk("s6_rx_ready", 32'(rx_ready), 32'd0);
        chk("s6_imem_we", 32'(imem_we), 32'd0);
        chk("s6_imem_addr", 32'(imem_addr), 32'd0);
        chk("s6_imem_wdata", imem_wdata, 32'd0);
        chk("s6_core_reset", 32'(core_reset), 32'd1);
        chk("s6_busy", 32'(busy), 32'd0);
        chk("s6_done", 32'(done), 32'd0);
        chk("s6_err", 32'(err), 32'd0);
        idle(3);
        reset = 1'b0;
        idle(1);
        clear_log();
        bq = '{8'hA5, 8'h02, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05,
               8'h11, 8'h22, 8'h33, 8'h44, 8'h69};
        send_q();
        idle(2);
        check_s1("s6");

        // Randomized frames with noise, gaps, bad checksums and bad lengths.
        for (int f = 0; f < 30; f++) begin
            repeat ($urandom_range(3)) begin
                nb = 8'($urandom);
                if (nb == SYNC) nb = 8'h00;
                send(nb);
            end
            if ($urandom_range(9) == 0) len = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(600, 257));
            else len = int'($urandom_range(8, 1));
            bad = ($urandom_range(3) == 0);
            fw.delete();
            for (int i = 0; i < len && i < 256; i++) fw.push_back($urandom);
            send_frame(len, bad, 30);
            idle($urandom_range(3));
        end
        idle(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
